bf_stim_gen: RTL
================

// Module: bf_stim_gen
// PURPOSE
//   Synchronous stimulus source for the 1-bit boolean-function stage (inputs a,b,c; output x).
//   Drives a, b, c as square waves with independent half-periods for a fixed run length.
//   Start/stop/done handshake. Sits directly upstream of the boolean stage, so hardware
//   (or a bench) can sweep its inputs without free-running testbench code.
// PARAMETERS
//   HP_A     20    half-period of a, in clk cycles (>=1)
//   HP_B     30    half-period of b, in clk cycles (>=1)
//   HP_C     40    half-period of c, in clk cycles (>=1)
//   RUN_LEN  1000  cycles spent in RUN per start (>=1, < 2**CW)
//   CW       16    width of cycle/phase counters
// PORTS
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   level-sampled; begins a run when sampled in IDLE
//   stop     in   1   synchronous abort; returns to IDLE with no done pulse
//   busy     out  1   1 while in RUN
//   done     out  1   one-cycle pulse on normal run completion
//   a        out  1   stimulus to boolean stage input a
//   b        out  1   stimulus to boolean stage input b
//   c        out  1   stimulus to boolean stage input c
//   cyc_cnt  out  CW  cycle index inside current run; 0 outside RUN
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, a=b=c=0, cyc_cnt=0, all phase counters 0.
//   - FSM IDLE -> RUN -> DONE -> IDLE; all outputs registered.
//   - IDLE: start=1 && stop=0 sampled -> next edge RUN, cyc_cnt=0, a=b=c=0, busy=1.
//   - RUN: cyc_cnt +1 per cycle; a = (cyc_cnt/HP_A) mod 2, likewise b with HP_B, c with HP_C.
//     Each channel uses its own phase counter: at HP-1 it wraps to 0 and the output toggles
//     on that edge. No divider.
//   - RUN with cyc_cnt==RUN_LEN-1 -> next edge DONE: done=1, busy=0, a=b=c=0, cyc_cnt=0.
//   - DONE lasts exactly one cycle, then IDLE unconditionally; start is ignored in DONE.
//   - start is ignored in RUN; re-arming needs start sampled in IDLE. Start held high gives
//     back-to-back runs, 2 idle-side cycles apart (DONE, IDLE).
//   - stop=1 in RUN: next edge IDLE, busy=0, a=b=c=0, cyc_cnt=0, done stays 0.
//   - stop and terminal count in the same cycle: stop wins, no done pulse.
//   - stop and start together in IDLE: stop wins, remain IDLE.
//   - HP >= RUN_LEN: that channel never toggles (stays 0); legal.
//   - Reset asserted mid-run: immediate return to reset values; no done pulse.
//     Run resumes only on a fresh start.
// CONFIGURATION
//   BF_STIM_EXH_EN defined: exhaustive mode. {a,b,c} (a = MSB) is a 3-bit binary counter.
//     Starts 3'b000 on RUN entry, +1 every HP_A cycles, wraps 3'b111 -> 3'b000.
//     HP_B and HP_C are unused. Ports, FSM and handshake are unchanged.
//   BF_STIM_EXH_EN undefined: independent square waves as described above.
// TESTING
//   1. Reset, then start pulse 1 cycle -> busy=1 the next cycle; a rises at cyc_cnt=20,
//      b at 30, c at 40; a falls at 40; a=0,b=1,c=1 at cyc_cnt=59.
//   2. Full run with defaults -> busy high exactly 1000 cycles; done=1 for exactly 1 cycle
//      when busy falls; a=b=c=0 thereafter.
//   3. stop at cyc_cnt=500 -> IDLE next edge, busy=0, done never asserts,
//      cyc_cnt=0, a=b=c=0.
//   4. start held high continuously -> RUN, DONE, IDLE, RUN repeating;
//      each done pulse 1002 cycles apart.
//   5. rst_n low at cyc_cnt=300 -> all outputs 0 asynchronously (before next clk edge);
//      after release, stays IDLE until start.
//   6. BF_STIM_EXH_EN, HP_A=4 -> {a,b,c}=000,001,...,111,000 changing at cyc_cnt=4,8,...,32.

Source files
------------

// File: rtl/bf_stim_gen.sv
// Square-wave stimulus source for the a/b/c boolean stage with start/stop/done handshake.
// Define BF_STIM_EXH_EN to step {a,b,c} as a 3-bit counter every HP_A cycles instead.
module bf_stim_gen #(
  parameter int HP_A    = 20,
  parameter int HP_B    = 30,
  parameter int HP_C    = 40,
  parameter int RUN_LEN = 1000,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic [CW-1:0] cyc_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] HA   = CW'(HP_A - 1);

  logic [1:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          c_q, c_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] pa_q, pa_d;
`ifndef BF_STIM_EXH_EN
  localparam logic [CW-1:0] HB = CW'(HP_B - 1);
  localparam logic [CW-1:0] HC = CW'(HP_C - 1);
  logic [CW-1:0] pb_q, pb_d;
  logic [CW-1:0] pc_q, pc_d;
`endif

  // Defaults are the idle values; only a continuing run holds anything.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    a_d     = 1'b0;
    b_d     = 1'b0;
    c_d     = 1'b0;
    cyc_d   = '0;
    pa_d    = '0;
`ifndef BF_STIM_EXH_EN
    pb_d    = '0;
    pc_d    = '0;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start && !stop) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      (state_q == S_RUN): begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cyc_q == LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          cyc_d  = cyc_q + 1'b1;
          a_d    = a_q;
          b_d    = b_q;
          c_d    = c_q;
          pa_d   = (pa_q == HA) ? '0 : pa_q + 1'b1;
`ifdef BF_STIM_EXH_EN
          if (pa_q == HA)
            {a_d, b_d, c_d} = {a_q, b_q, c_q} + 3'd1;
`else
          pb_d = (pb_q == HB) ? '0 : pb_q + 1'b1;
          pc_d = (pc_q == HC) ? '0 : pc_q + 1'b1;
          if (pa_q == HA) a_d = ~a_q;
          if (pb_q == HB) b_d = ~b_q;
          if (pc_q == HC) c_d = ~c_q;
`endif
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      cyc_q   <= '0;
      pa_q    <= '0;
`ifndef BF_STIM_EXH_EN
      pb_q    <= '0;
      pc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cyc_q   <= cyc_d;
      pa_q    <= pa_d;
`ifndef BF_STIM_EXH_EN
      pb_q    <= pb_d;
      pc_q    <= pc_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign cyc_cnt = cyc_q;

endmodule
